// File: rtl/branch_flush_sequencer_pkg.sv
// Shared types and defaults for the branch redirect / squash sequencer.
// Holds state encoding and a saturating-increment helper.
package branch_flush_sequencer_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int REG_W_DEF  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input logic [63:0] max
  );
    return (v == max) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/branch_flush_sequencer_load_use_detect.sv
// Load-use hazard comparator between the EX load and ID sources.
// Purely combinational; x0 never creates a hazard.
module branch_flush_sequencer_load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             hazard
);

  assign hazard = mem_read && (ex_rd != '0) &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/branch_flush_sequencer.sv
// Redirects PC and squashes IF/ID, ID/EX after a taken EX branch.
// Also stalls on load-use and counts taken redirects.
module branch_flush_sequencer
  import branch_flush_sequencer_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int REG_W        = REG_W_DEF,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              switch_branch,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              busy,
  output logic [CNT_W-1:0]  redirect_cnt
);

  localparam int FC_W =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [63:0]       cnt_inc;
  logic              hazard;
  logic              take;

  branch_flush_sequencer_load_use_detect #(
    .REG_W (REG_W)
  ) u_lud (
    .mem_read (ex_mem_read),
    .ex_rd    (ex_rd),
    .id_rs1   (id_rs1),
    .id_rs2   (id_rs2),
    .hazard   (hazard)
  );

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    take        = 1'b0;
    pc_sel      = 1'b0;
    pc_target   = '0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    busy        = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (switch_branch) begin
            take        = 1'b1;
            pc_sel      = 1'b1;
            pc_target   = branch_target;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
            end
          end else if (hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        FLUSH: begin
          if_id_flush = 1'b1;
          busy        = 1'b1;
          fcnt_d      = fcnt_q - 1'b1;
          if (fcnt_q <= FC_W'(1)) begin
            state_d = IDLE;
            fcnt_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Widened so the shared helper serves any CNT_W up to 64.
  assign cnt_inc = sat_inc(64'(cnt_q), 64'({CNT_W{1'b1}}));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (take) cnt_q <= cnt_inc[CNT_W-1:0];
    end
  end

  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_branch_flush_sequencer.sv
// Directed bench: two instances (FLUSH_CYCLES=1/CNT_W=16 and
// FLUSH_CYCLES=3/CNT_W=4) share one stimulus stream.
module tb_branch_flush_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        switch_branch;
  logic [63:0] branch_target;
  logic        ex_mem_read;
  logic [4:0]  ex_rd, id_rs1, id_rs2;

  logic        a_sel, a_pw, a_iw, a_iff, a_ief, a_busy;
  logic [63:0] a_tgt;
  logic [15:0] a_cnt;
  logic        b_sel, b_pw, b_iw, b_iff, b_ief, b_busy;
  logic [63:0] b_tgt;
  logic [3:0]  b_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_flush_sequencer #(
    .ADDR_W(64), .REG_W(5), .FLUSH_CYCLES(1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .reset(reset), .switch_branch(switch_branch),
    .branch_target(branch_target), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .pc_sel(a_sel), .pc_target(a_tgt), .pc_write(a_pw),
    .if_id_write(a_iw), .if_id_flush(a_iff), .id_ex_flush(a_ief),
    .busy(a_busy), .redirect_cnt(a_cnt)
  );

  branch_flush_sequencer #(
    .ADDR_W(64), .REG_W(5), .FLUSH_CYCLES(3), .CNT_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .switch_branch(switch_branch),
    .branch_target(branch_target), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .pc_sel(b_sel), .pc_target(b_tgt), .pc_write(b_pw),
    .if_id_write(b_iw), .if_id_flush(b_iff), .id_ex_flush(b_ief),
    .busy(b_busy), .redirect_cnt(b_cnt)
  );

  // Output vector order: {pc_sel, pc_write, if_id_write,
  // if_id_flush, id_ex_flush, busy}.
  wire [5:0] a_vec = {a_sel, a_pw, a_iw, a_iff, a_ief, a_busy};
  wire [5:0] b_vec = {b_sel, b_pw, b_iw, b_iff, b_ief, b_busy};

  task automatic idle_in();
    switch_branch = 1'b0;
    branch_target = 64'h0;
    ex_mem_read   = 1'b0;
    ex_rd  = 5'd0;
    id_rs1 = 5'd0;
    id_rs2 = 5'd0;
  endtask

  // Inputs change 1 time unit after posedge; checks run at negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    switch_branch = 1'b1;
    branch_target = 64'h55;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_vec !== 6'b011000 || a_tgt !== 64'h0 || a_cnt !== 16'd0) begin
        n_err++;
        $display("FAIL reset_a cyc%0d: vec=%b tgt=%h cnt=%0d want 011000/0/0",
                 i, a_vec, a_tgt, a_cnt);
      end
      n_cmp++;
      if (b_vec !== 6'b011000 || b_tgt !== 64'h0 || b_cnt !== 4'd0) begin
        n_err++;
        $display("FAIL reset_b cyc%0d: vec=%b tgt=%h cnt=%0d want 011000/0/0",
                 i, b_vec, b_tgt, b_cnt);
      end
      next_cycle();
    end
    reset = 1'b0;
    idle_in();
    @(negedge clk);
    n_cmp++;
    if (a_vec !== 6'b011000 || b_vec !== 6'b011000 || b_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL post_reset: a=%b b=%b bcnt=%0d want 011000/011000/0",
               a_vec, b_vec, b_cnt);
    end
    next_cycle();
  endtask

  // Branch at t; a second branch at t+1 is taken by A, ignored by B.
  // Then back-to-back: branch in B's first IDLE cycle after FLUSH.
  task automatic test_branch();
    switch_branch = 1'b1;
    branch_target = 64'h100;
    @(negedge clk);
    n_cmp++;
    if (a_vec !== 6'b111110 || a_tgt !== 64'h100) begin
      n_err++;
      $display("FAIL branch_a_t: vec=%b tgt=%h want 111110/100", a_vec, a_tgt);
    end
    n_cmp++;
    if (b_vec !== 6'b111110 || b_tgt !== 64'h100) begin
      n_err++;
      $display("FAIL branch_b_t: vec=%b tgt=%h want 111110/100", b_vec, b_tgt);
    end
    next_cycle();
    // t+1
    branch_target = 64'h180;
    @(negedge clk);
    n_cmp++;
    if (a_cnt !== 16'd1 || a_vec !== 6'b111110 || a_tgt !== 64'h180) begin
      n_err++;
      $display("FAIL branch_a_t1: cnt=%0d vec=%b tgt=%h want 1/111110/180",
               a_cnt, a_vec, a_tgt);
    end
    n_cmp++;
    if (b_vec !== 6'b011101 || b_tgt !== 64'h0 || b_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL flush_b_t1: vec=%b tgt=%h cnt=%0d want 011101/0/1",
               b_vec, b_tgt, b_cnt);
    end
    next_cycle();
    // t+2
    idle_in();
    @(negedge clk);
    n_cmp++;
    if (b_vec !== 6'b011101 || b_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL flush_b_t2: vec=%b cnt=%0d want 011101/1", b_vec, b_cnt);
    end
    n_cmp++;
    if (a_vec !== 6'b011000 || a_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL idle_a_t2: vec=%b cnt=%0d want 011000/2", a_vec, a_cnt);
    end
    next_cycle();
    // t+3: B idle again, immediate new branch
    switch_branch = 1'b1;
    branch_target = 64'h200;
    @(negedge clk);
    n_cmp++;
    if (b_vec !== 6'b111110 || b_tgt !== 64'h200 || b_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL b2b_b: vec=%b tgt=%h cnt=%0d want 111110/200/1",
               b_vec, b_tgt, b_cnt);
    end
    next_cycle();
    idle_in();
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (b_vec !== 6'b011000 || b_cnt !== 4'd2 || a_cnt !== 16'd3) begin
      n_err++;
      $display("FAIL b2b_done: bvec=%b bcnt=%0d acnt=%0d want 011000/2/3",
               b_vec, b_cnt, a_cnt);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1;
    ex_rd  = 5'd5;
    id_rs1 = 5'd3;
    id_rs2 = 5'd5;
    @(negedge clk);
    n_cmp++;
    if (a_vec !== 6'b000010 || b_vec !== 6'b000010) begin
      n_err++;
      $display("FAIL lu_rs2: a=%b b=%b want 000010", a_vec, b_vec);
    end
    next_cycle();
    ex_rd  = 5'd7;
    id_rs1 = 5'd7;
    id_rs2 = 5'd1;
    @(negedge clk);
    n_cmp++;
    if (a_vec !== 6'b000010) begin
      n_err++;
      $display("FAIL lu_rs1: a=%b want 000010", a_vec);
    end
    next_cycle();
    ex_rd  = 5'd0;
    id_rs1 = 5'd0;
    id_rs2 = 5'd4;
    @(negedge clk);
    n_cmp++;
    if (a_vec !== 6'b011000 || b_vec !== 6'b011000) begin
      n_err++;
      $display("FAIL lu_x0: a=%b b=%b want 011000", a_vec, b_vec);
    end
    next_cycle();
    ex_mem_read = 1'b0;
    ex_rd  = 5'd9;
    id_rs1 = 5'd9;
    @(negedge clk);
    n_cmp++;
    if (a_vec !== 6'b011000) begin
      n_err++;
      $display("FAIL lu_noload: a=%b want 011000", a_vec);
    end
    next_cycle();
    idle_in();
  endtask

  task automatic test_branch_vs_load_use();
    ex_mem_read   = 1'b1;
    ex_rd         = 5'd5;
    id_rs2        = 5'd5;
    switch_branch = 1'b1;
    branch_target = 64'h300;
    @(negedge clk);
    n_cmp++;
    if (a_vec !== 6'b111110 || a_tgt !== 64'h300) begin
      n_err++;
      $display("FAIL br_lu_a: vec=%b tgt=%h want 111110/300", a_vec, a_tgt);
    end
    n_cmp++;
    if (b_vec !== 6'b111110) begin
      n_err++;
      $display("FAIL br_lu_b: vec=%b want 111110", b_vec);
    end
    next_cycle();
    // Still a load-use hazard, but B is flushing and must ignore it.
    switch_branch = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b_vec !== 6'b011101) begin
      n_err++;
      $display("FAIL flush_ign_lu: vec=%b want 011101", b_vec);
    end
    next_cycle();
    idle_in();
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (b_cnt !== 4'd3 || a_cnt !== 16'd4) begin
      n_err++;
      $display("FAIL cnt_after_brlu: b=%0d a=%0d want 3/4", b_cnt, a_cnt);
    end
    next_cycle();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 17; i++) begin
      switch_branch = 1'b1;
      branch_target = 64'h1000 + 64'(i);
      next_cycle();
      switch_branch = 1'b0;
      next_cycle();
      next_cycle();
    end
    @(negedge clk);
    n_cmp++;
    if (b_cnt !== 4'd15) begin
      n_err++;
      $display("FAIL sat_b: cnt=%0d want 15", b_cnt);
    end
    n_cmp++;
    if (a_cnt !== 16'd21) begin
      n_err++;
      $display("FAIL count_a: cnt=%0d want 21", a_cnt);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_flush();
    switch_branch = 1'b1;
    branch_target = 64'h400;
    next_cycle();
    switch_branch = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b_busy !== 1'b1) begin
      n_err++;
      $display("FAIL pre_rst_busy: busy=%b want 1", b_busy);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (b_vec !== 6'b011000) begin
      n_err++;
      $display("FAIL rst_force_b: vec=%b want 011000", b_vec);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b_vec !== 6'b011000 || b_cnt !== 4'd0 || a_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL rst_mid_flush: vec=%b bcnt=%0d acnt=%0d want 011000/0/0",
               b_vec, b_cnt, a_cnt);
    end
    next_cycle();
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    #1;
    test_reset();
    test_branch();
    test_load_use();
    test_branch_vs_load_use();
    test_saturate();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
